// File: rtl/cg_sleep_pkg.sv
// Shared types for the core clock-gate sleep controller.
// Holds the FSM state encoding and the width of the shared phase counter.
package cg_sleep_pkg;

    localparam int CG_CNT_W = 8;

    typedef enum logic [1:0] {
        CG_RUN,
        CG_DRAIN,
        CG_GATED,
        CG_WAKE
    } cg_state_e;

endpackage

// File: rtl/cg_sleep_ctrl_sat_counter.sv
// Saturating up-counter for the gated-cycle statistics.
// Ports: clk_i, rst_ni (async low), inc_i, cnt_o (holds at all-ones).
module cg_sleep_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/cg_sleep_ctrl.sv
// Clock-gate enable sequencer for WFI sleep; runs on the free-running clock.
// Ports: clk_i, rst_ni, sleep_req_i, core_idle_i, wake_i, scan_mode_i in;
// gate_en_o, sleeping_o, wake_ack_o, gated_cycles_o out.
// Optional gated-cycle statistics: define CG_SLEEP_STATS_EN.
module cg_sleep_ctrl
    import cg_sleep_pkg::*;
#(
    parameter int IDLE_HOLD   = 4,
    parameter int WAKE_SETTLE = 2,
    parameter int STAT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sleep_req_i,
    input  logic              core_idle_i,
    input  logic              wake_i,
    input  logic              scan_mode_i,
    output logic              gate_en_o,
    output logic              sleeping_o,
    output logic              wake_ack_o,
    output logic [STAT_W-1:0] gated_cycles_o
);

    localparam logic [CG_CNT_W-1:0] IDLE_LAST   = CG_CNT_W'(IDLE_HOLD - 1);
    localparam logic [CG_CNT_W-1:0] SETTLE_LAST = CG_CNT_W'(WAKE_SETTLE - 1);

    cg_state_e           state_q, state_d;
    logic [CG_CNT_W-1:0] cnt_q, cnt_d;
    logic                ack_d;
    logic                gate_en_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        unique case (state_q)
            CG_RUN: begin
                if (sleep_req_i && !wake_i) begin
                    state_d = CG_DRAIN;
                    cnt_d   = '0;
                end
            end
            CG_DRAIN: begin
                // abort outranks gating in the same cycle
                if (wake_i || !sleep_req_i) begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end else if (!core_idle_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = CG_GATED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CG_CNT_W'(1);
                end
            end
            CG_GATED: begin
                if (wake_i) begin
                    state_d = CG_WAKE;
                    cnt_d   = '0;
                end
            end
            CG_WAKE: begin
                // wake always completes, even if wake_i drops
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CG_CNT_W'(1);
                end
            end
            default: begin
                state_d = CG_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // gate enable is its own flop off next-state so it never glitches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CG_RUN;
            cnt_q      <= '0;
            gate_en_q  <= 1'b1;
            sleeping_o <= 1'b0;
            wake_ack_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gate_en_q  <= (state_d != CG_GATED);
            sleeping_o <= (state_d == CG_GATED) || (state_d == CG_WAKE);
            wake_ack_o <= ack_d;
        end
    end

    assign gate_en_o = gate_en_q | scan_mode_i;

`ifdef CG_SLEEP_STATS_EN
    cg_sleep_ctrl_sat_counter #(
        .W(STAT_W)
    ) u_stat (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (state_q == CG_GATED),
        .cnt_o  (gated_cycles_o)
    );
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cg_sleep_ctrl.sv
// Directed bench for cg_sleep_ctrl: reset, sleep/wake latency, idle glitch,
// abort race, scan override, async reset in GATED, optional statistics.
`timescale 1ns/1ps
module tb_cg_sleep_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        sleep_req;
    logic        core_idle;
    logic        wake;
    logic        scan_mode;
    logic        gate_en;
    logic        sleeping;
    logic        wake_ack;
    logic [31:0] gated_cycles;
    logic        gate_en4;
    logic        sleeping4;
    logic        wake_ack4;
    logic [3:0]  gated_cycles4;

    int n_vec = 0;
    int n_err = 0;

`ifdef CG_SLEEP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    cg_sleep_ctrl #(
        .IDLE_HOLD   (4),
        .WAKE_SETTLE (2),
        .STAT_W      (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .sleep_req_i    (sleep_req),
        .core_idle_i    (core_idle),
        .wake_i         (wake),
        .scan_mode_i    (scan_mode),
        .gate_en_o      (gate_en),
        .sleeping_o     (sleeping),
        .wake_ack_o     (wake_ack),
        .gated_cycles_o (gated_cycles)
    );

    cg_sleep_ctrl #(
        .IDLE_HOLD   (4),
        .WAKE_SETTLE (2),
        .STAT_W      (4)
    ) dut4 (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .sleep_req_i    (sleep_req),
        .core_idle_i    (core_idle),
        .wake_i         (wake),
        .scan_mode_i    (scan_mode),
        .gate_en_o      (gate_en4),
        .sleeping_o     (sleeping4),
        .wake_ack_o     (wake_ack4),
        .gated_cycles_o (gated_cycles4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni    = 1'b0;
        sleep_req = 1'b0;
        core_idle = 1'b0;
        wake      = 1'b0;
        scan_mode = 1'b0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_gate", gate_en, 1);
        check("rst_sleeping", sleeping, 0);
        check("rst_ack", wake_ack, 0);
        check("rst_stats", gated_cycles, 0);
        rst_ni = 1'b1;
        step();
        check("run_gate", gate_en, 1);
        check("run_sleeping", sleeping, 0);

        // basic sleep: gate at cycle 5, wake at 10, ack at 13
        sleep_req = 1'b1;
        core_idle = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("drain_gate_c%0d", i), gate_en, 1);
        end
        step();
        check("gated_c5", gate_en, 0);
        check("sleeping_c5", sleeping, 1);
        repeat (5) step();
        check("gated_c10", gate_en, 0);
        wake      = 1'b1;
        sleep_req = 1'b0;
        step();
        check("wake_gate_c11", gate_en, 1);
        check("wake_sleeping_c11", sleeping, 1);
        check("wake_ack_c11", wake_ack, 0);
        wake = 1'b0;
        step();
        check("wake_ack_c12", wake_ack, 0);
        check("wake_sleeping_c12", sleeping, 1);
        step();
        check("wake_ack_c13", wake_ack, 1);
        check("wake_sleeping_c13", sleeping, 0);
        check("wake_gate_c13", gate_en, 1);
        step();
        check("wake_ack_c14", wake_ack, 0);

        // idle glitch in third DRAIN cycle: gate at cycle 8
        sleep_req = 1'b1;
        core_idle = 1'b1;
        step();
        step();
        step();
        core_idle = 1'b0;
        step();
        core_idle = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            step();
            check($sformatf("glitch_gate_c%0d", i), gate_en, 1);
        end
        step();
        check("glitch_gated_c8", gate_en, 0);
        wake      = 1'b1;
        sleep_req = 1'b0;
        step();
        wake = 1'b0;
        step();
        step();
        check("glitch_ack", wake_ack, 1);
        step();

        // abort race: wake on the gating cycle
        sleep_req = 1'b1;
        core_idle = 1'b1;
        repeat (4) step();
        wake = 1'b1;
        step();
        check("abort_gate", gate_en, 1);
        check("abort_sleeping", sleeping, 0);
        wake      = 1'b0;
        sleep_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("abort_hold_%0d", i), gate_en, 1);
        end

        // fresh reset, then 20 gated cycles for statistics
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        sleep_req = 1'b1;
        core_idle = 1'b1;
        repeat (5) step();
        check("stat_gated", gate_en, 0);
        check("stat_start", gated_cycles, 0);
        repeat (20) step();
        check("stat_20", gated_cycles, STATS ? 32'd20 : 32'd0);
        check("stat_sat4", {28'd0, gated_cycles4}, STATS ? 32'd15 : 32'd0);

        // scan override while GATED
        scan_mode = 1'b1;
        #1;
        check("scan_gate", gate_en, 1);
        check("scan_sleeping", sleeping, 1);
        step();
        check("scan_gate_hold", gate_en, 1);
        check("scan_sleeping_hold", sleeping, 1);
        scan_mode = 1'b0;
        #1;
        check("scan_off_gate", gate_en, 0);

        // asynchronous reset mid-sleep
        rst_ni = 1'b0;
        #1;
        check("arst_gate", gate_en, 1);
        check("arst_sleeping", sleeping, 0);
        check("arst_stats", gated_cycles, 0);
        sleep_req = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_gate", gate_en, 1);
        check("post_rst_sleeping", sleeping, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
